// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch with credit-limited requests, redirect flush and a decoupling FIFO
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRValid,
  input  logic [31:0] imemRData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] fetchPc, respPc, credit;
  logic [2:0]  outstanding, dropCount;
  logic [AW:0] wrPtr, rdPtr, occupancy;
  logic [31:0] fifoPc [DEPTH];
  logic [31:0] fifoInstr [DEPTH];
  logic        grant, rsp, enq, deq;
  assign instrValid = wrPtr != rdPtr;
  assign instr = instrValid ? fifoInstr[rdPtr[AW-1:0]] : '0;
  assign instrPc = instrValid ? fifoPc[rdPtr[AW-1:0]] : '0;
  assign imemAddr = fetchPc;
  // credit check counts buffered plus live in-flight words so the FIFO can never overflow
  always_comb begin
    occupancy = wrPtr - rdPtr;
    credit = 32'(occupancy) + 32'(outstanding) - 32'(dropCount);
    imemReq = !reset && !redirect && 32'(outstanding) < 32'(MAX_OUTSTANDING) && credit < 32'(DEPTH);
    grant = imemReq && imemGnt;
    rsp = imemRValid && outstanding != '0;
    enq = rsp && dropCount == '0 && !redirect;
    deq = instrValid && instrReady && !redirect;
  end
  // fetch/response bookkeeping; a redirect flushes the FIFO and turns in-flight requests into drops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetchPc <= RESET_PC;
      respPc <= RESET_PC;
      outstanding <= '0;
      dropCount <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (redirect) begin
      fetchPc <= {redirectPc[31:2], 2'b00};
      respPc <= {redirectPc[31:2], 2'b00};
      outstanding <= outstanding - 3'(rsp);
      dropCount <= outstanding - 3'(rsp);
      rdPtr <= wrPtr;
    end else begin
      if (grant) fetchPc <= fetchPc + 32'd4;
      if (enq) respPc <= respPc + 32'd4;
      outstanding <= outstanding + 3'(grant) - 3'(rsp);
      if (rsp && dropCount != '0) dropCount <= dropCount - 3'd1;
      if (enq) wrPtr <= wrPtr + (AW+1)'(1);
      if (deq) rdPtr <= rdPtr + (AW+1)'(1);
    end
  // entry storage needs no reset: outputs are gated by instrValid
  always_ff @(posedge clk)
    if (enq) begin
      fifoPc[wrPtr[AW-1:0]] <= respPc;
      fifoInstr[wrPtr[AW-1:0]] <= imemRData;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized bench against an epoch-tagged request/queue model
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 0, reset = 1, redirect = 0, imemGnt = 0, imemRValid = 0, instrReady = 0;
  logic [31:0] redirectPc = 0, imemRData = 0;
  logic imemReq, instrValid;
  logic [31:0] imemAddr, instr, instrPc;
  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirectPc(redirectPc),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRValid(imemRValid), .imemRData(imemRData),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .instrPc(instrPc)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int ep; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  req_t pend[$];
  ent_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, epoch = 0, lat = 1, delivered = 0;
  int pGnt, pReady, pRedir, pRv, pStray;
  bit redirOnRv = 0, firedRv = 0, forceRedir = 0;
  logic [31:0] forcePc = 0, fetchPc = RPC;
  function automatic logic [31:0] memWord(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic cycle();
    int cur;
    logic expReq, rvHit;
    @(negedge clk);
    redirect = $urandom_range(99) < pRedir;
    redirectPc = $urandom;
    imemGnt = $urandom_range(99) < pGnt;
    instrReady = $urandom_range(99) < pReady;
    rvHit = pend.size() != 0 && pend[0].due <= cyc && $urandom_range(99) < pRv;
    imemRValid = rvHit || (pend.size() == 0 && $urandom_range(99) < pStray);
    imemRData = rvHit ? memWord(pend[0].addr) : $urandom;
    if (redirOnRv && rvHit) begin
      redirect = 1;
      redirectPc = 32'h103;
      firedRv = 1;
    end
    if (forceRedir) begin
      redirect = 1;
      redirectPc = forcePc;
    end
    cur = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) cur++;
    expReq = !redirect && pend.size() < MAXO && q.size() + cur < DEPTH;
    #1;
    check("imemReq", 32'(imemReq), 32'(expReq));
    if (expReq) check("imemAddr", imemAddr, fetchPc);
    check("instrValid", 32'(instrValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("instrPc", instrPc, q[0].pc);
      check("instr", instr, q[0].ins);
    end
    if (redirect) begin
      q.delete();
      epoch++;
      fetchPc = {redirectPc[31:2], 2'b00};
      if (rvHit) void'(pend.pop_front());
    end else begin
      if (q.size() != 0 && instrReady) begin
        void'(q.pop_front());
        delivered++;
      end
      if (rvHit) begin
        req_t h = pend.pop_front();
        if (h.ep == epoch) q.push_back('{h.addr, memWord(h.addr)});
      end
      if (expReq && imemGnt) begin
        pend.push_back('{fetchPc, epoch, cyc + lat});
        fetchPc += 4;
      end
    end
    cyc++;
  endtask
  task automatic midReset();
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("rst instrValid", 32'(instrValid), 0);
    check("rst imemReq", 32'(imemReq), 0);
    q.delete();
    pend.delete();
    fetchPc = RPC;
    epoch++;
    imemRValid = 0;
    imemGnt = 0;
    redirect = 0;
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    int d0;
    pGnt = 100; pReady = 100; pRedir = 0; pRv = 100; pStray = 0; lat = 1;
    #12;
    check("reset instrValid", 32'(instrValid), 0);
    check("reset imemReq", 32'(imemReq), 0);
    check("reset instr", instr, 0);
    check("reset instrPc", instrPc, 0);
    @(negedge clk);
    reset = 0;
    repeat (10) cycle();
    d0 = delivered;
    repeat (20) cycle();
    check("throughput", 32'(delivered - d0), 20);
    pReady = 0;
    repeat (12) cycle();
    check("full imemReq", 32'(imemReq), 0);
    check("full instrValid", 32'(instrValid), 1);
    pReady = 100;
    repeat (8) cycle();
    lat = 3;
    repeat (6) cycle();
    forceRedir = 1; forcePc = 32'h40;
    cycle();
    forceRedir = 0;
    repeat (10) cycle();
    lat = 2;
    redirOnRv = 1;
    for (int i = 0; i < 20 && !firedRv; i++) cycle();
    redirOnRv = 0;
    check("redirect on rvalid fired", 32'(firedRv), 1);
    pGnt = 100;
    cycle();
    repeat (6) cycle();
    pGnt = 70; pReady = 60; pRedir = 4; pRv = 70; pStray = 5;
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 4);
      cycle();
      if (i % 300 == 150) midReset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
